// File: rtl/stack_op_sequencer.sv
// Operand-stack initiator: pops operands, runs the 8-bit ALU and pushes the result,
// keeping a shadow occupancy count so that underflow, overflow and pop timeouts are reported.
module stack_op_sequencer #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 256,
   parameter int TIMEOUT = 15
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [2:0]       cmd_op_i,
   input  logic [WIDTH-1:0] cmd_imm_i,
   output logic             st_push_o,
   output logic             st_pop_o,
   output logic [WIDTH-1:0] st_b_o,
   input  logic [WIDTH-1:0] st_out_i,
   input  logic             st_pop_done_i,
   output logic [WIDTH-1:0] result_o,
   output logic             done_o,
   output logic [1:0]       error_o,
   output logic [8:0]       depth_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] OP_PUSHI = 3'd0, OP_ADD = 3'd1, OP_SUB  = 3'd2, OP_AND  = 3'd3,
                          OP_OR    = 3'd4, OP_XOR = 3'd5, OP_DUP  = 3'd6, OP_DROP = 3'd7;

   localparam logic [1:0] ERR_OK = 2'd0, ERR_UNDER = 2'd1, ERR_OVER = 2'd2, ERR_TMO = 2'd3;

   typedef enum logic [3:0] {
      IDLE, POP_A, WAIT_A, POP_B, WAIT_B, EXEC, PUSH1, GAP, PUSH2, DONE
   } state_t;

   state_t           state_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] imm_q, a_q, b_q, st_b_q, result_q;
   logic [CW-1:0]    cnt_q;
   logic [8:0]       depth_q;
   logic [1:0]       error_q;
   logic             cmd_ready_q, st_push_q, st_pop_q, done_q;

   logic [1:0]       need_d;
   logic             grow_d, under_d, over_d;
   logic [WIDTH-1:0] alu_d;

   always_comb begin
      need_d = 2'd2;
      grow_d = 1'b0;
      case (cmd_op_i)
         OP_PUSHI: begin need_d = 2'd0; grow_d = 1'b1; end
         OP_DUP:   begin need_d = 2'd1; grow_d = 1'b1; end
         OP_DROP:  need_d = 2'd1;
         default:  need_d = 2'd2;
      endcase
      under_d = {7'd0, need_d} > depth_q;
      over_d  = ({1'b0, depth_q} + {9'd0, grow_d}) > 10'(DEPTH);

      // B is the deeper operand, so SUB yields B-A
      case (op_q)
         OP_PUSHI: alu_d = imm_q;
         OP_ADD:   alu_d = b_q + a_q;
         OP_SUB:   alu_d = b_q - a_q;
         OP_AND:   alu_d = b_q & a_q;
         OP_OR:    alu_d = b_q | a_q;
         OP_XOR:   alu_d = b_q ^ a_q;
         default:  alu_d = a_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         op_q        <= OP_PUSHI;
         imm_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         st_b_q      <= '0;
         result_q    <= '0;
         cnt_q       <= '0;
         depth_q     <= '0;
         error_q     <= ERR_OK;
         cmd_ready_q <= 1'b1;
         st_push_q   <= 1'b0;
         st_pop_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         st_push_q <= 1'b0;
         st_pop_q  <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            IDLE: if (cmd_valid_i && cmd_ready_q) begin
               op_q        <= cmd_op_i;
               imm_q       <= cmd_imm_i;
               cmd_ready_q <= 1'b0;
               if (under_d) begin
                  state_q <= DONE; done_q <= 1'b1; error_q <= ERR_UNDER;
               end else if (over_d) begin
                  state_q <= DONE; done_q <= 1'b1; error_q <= ERR_OVER;
               end else if (cmd_op_i == OP_PUSHI) begin
                  state_q <= EXEC;
               end else begin
                  state_q  <= POP_A;
                  st_pop_q <= 1'b1;
                  depth_q  <= depth_q - 9'd1;
               end
            end
            POP_A: begin
               state_q <= WAIT_A;
               cnt_q   <= '0;
            end
            WAIT_A: begin
               if (st_pop_done_i) begin
                  a_q <= st_out_i;
                  if (op_q == OP_DUP) begin
                     state_q <= EXEC;
                  end else if (op_q == OP_DROP) begin
                     result_q <= st_out_i;
                     state_q  <= DONE; done_q <= 1'b1; error_q <= ERR_OK;
                  end else begin
                     state_q  <= POP_B;
                     st_pop_q <= 1'b1;
                     depth_q  <= depth_q - 9'd1;
                  end
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  state_q <= DONE; done_q <= 1'b1; error_q <= ERR_TMO;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            POP_B: begin
               state_q <= WAIT_B;
               cnt_q   <= '0;
            end
            WAIT_B: begin
               if (st_pop_done_i) begin
                  b_q     <= st_out_i;
                  state_q <= EXEC;
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  state_q <= DONE; done_q <= 1'b1; error_q <= ERR_TMO;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            EXEC: begin
               state_q   <= PUSH1;
               st_push_q <= 1'b1;
               st_b_q    <= alu_d;
               result_q  <= alu_d;
               depth_q   <= depth_q + 9'd1;
            end
            PUSH1: begin
               if (op_q == OP_DUP) begin
                  state_q <= GAP;
               end else begin
                  state_q <= DONE; done_q <= 1'b1; error_q <= ERR_OK;
               end
            end
            // st_b still holds the duplicated value for the second push
            GAP: begin
               state_q   <= PUSH2;
               st_push_q <= 1'b1;
               depth_q   <= depth_q + 9'd1;
            end
            PUSH2: begin
               state_q <= DONE; done_q <= 1'b1; error_q <= ERR_OK;
            end
            DONE: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign st_push_o   = st_push_q;
   assign st_pop_o    = st_pop_q;
   assign st_b_o      = st_b_q;
   assign result_o    = result_q;
   assign done_o      = done_q;
   assign error_o     = error_q;
   assign depth_o     = depth_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: emulates the stack block and predicts each instruction
// from a queue-based model of the operand stack.
module tb_stack_op_sequencer;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       cmd_valid_i = 1'b0;
   logic       cmd_ready_o;
   logic [2:0] cmd_op_i = 3'd0;
   logic [7:0] cmd_imm_i = 8'd0;
   logic       st_push_o, st_pop_o;
   logic [7:0] st_b_o;
   logic [7:0] st_out_i = 8'd0;
   logic       st_pop_done_i = 1'b0;
   logic [7:0] result_o;
   logic       done_o;
   logic [1:0] error_o;
   logic [8:0] depth_o;

   stack_op_sequencer #(.WIDTH(8), .DEPTH(256), .TIMEOUT(15)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_op_i(cmd_op_i), .cmd_imm_i(cmd_imm_i),
      .st_push_o(st_push_o), .st_pop_o(st_pop_o), .st_b_o(st_b_o),
      .st_out_i(st_out_i), .st_pop_done_i(st_pop_done_i),
      .result_o(result_o), .done_o(done_o), .error_o(error_o), .depth_o(depth_o)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [2:0] PUSHI = 3'd0, ADD = 3'd1, SUB = 3'd2, ANDO = 3'd3,
                          ORO = 3'd4, XORO = 3'd5, DUP = 3'd6, DROP = 3'd7;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [7:0]  stk[$];      // contents as seen by the emulated stack
   logic [7:0]  ref_stk[$];  // contents predicted by the model
   logic [7:0]  exp_res = 8'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // lat_a/lat_b: cycles from each pop strobe to its response, 0 = withheld
   task automatic run(input logic [2:0] op, input logic [7:0] imm, input int lat_a, input int lat_b);
      int need, grow, sz, exp_err, exp_n, exp_pops, exp_pushes, exp_first;
      int n, done_n, pops, pushes, first_push, last_push, pidx, pd_at;
      logic [7:0] a, b, r, pend;
      logic both, same, got_err, got_ready;
      logic [7:0] got_res;
      // ---- model ----
      need = (op == PUSHI) ? 0 : (op == DUP || op == DROP) ? 1 : 2;
      grow = (op == PUSHI || op == DUP) ? 1 : 0;
      sz = ref_stk.size();
      exp_err = 0; exp_pops = 0; exp_pushes = 0; exp_first = -1;
      if (sz < need) begin
         exp_err = 1; exp_n = 1;
      end else if (sz + grow > 256) begin
         exp_err = 2; exp_n = 1;
      end else if (op == PUSHI) begin
         ref_stk.push_back(imm); exp_res = imm; exp_n = 3; exp_pushes = 1; exp_first = 2;
      end else begin
         a = ref_stk.pop_back(); exp_pops = 1;
         if (lat_a == 0) begin
            exp_err = 3; exp_n = 17;
         end else if (op == DROP) begin
            exp_res = a; exp_n = 2 + lat_a;
         end else if (op == DUP) begin
            ref_stk.push_back(a); ref_stk.push_back(a); exp_res = a;
            exp_n = 6 + lat_a; exp_pushes = 2; exp_first = exp_n - 3;
         end else begin
            b = ref_stk.pop_back(); exp_pops = 2;
            if (lat_b == 0) begin
               exp_err = 3; exp_n = 18 + lat_a;
            end else begin
               case (op)
                  ADD:     r = b + a;
                  SUB:     r = b - a;
                  ANDO:    r = b & a;
                  ORO:     r = b | a;
                  default: r = b ^ a;
               endcase
               ref_stk.push_back(r); exp_res = r;
               exp_n = 5 + lat_a + lat_b; exp_pushes = 1; exp_first = exp_n - 1;
            end
         end
      end
      // ---- drive and emulate the stack ----
      got_ready = 1'b0;
      for (int w = 0; w < 20 && !got_ready; w++) begin
         @(negedge clk_i);
         got_ready = cmd_ready_o;
      end
      check("cmd_ready", 32'(got_ready), 32'd1);
      cmd_valid_i = 1'b1; cmd_op_i = op; cmd_imm_i = imm;
      @(posedge clk_i);
      done_n = -1; pops = 0; pushes = 0; first_push = -1; last_push = -1;
      pidx = 0; pd_at = -1; both = 1'b0; pend = 8'd0; got_err = 1'b0; got_res = 8'd0;
      for (n = 1; n <= 80 && done_n < 0; n++) begin
         @(negedge clk_i);
         cmd_valid_i = 1'b0;
         st_pop_done_i = (pd_at == n);
         if (pd_at == n) st_out_i = pend;
         if (st_push_o && st_pop_o) both = 1'b1;
         if (st_pop_o) begin
            pops++; pidx++;
            pend = (stk.size() > 0) ? stk.pop_back() : 8'h00;
            pd_at = ((pidx == 1 ? lat_a : lat_b) > 0) ? n + (pidx == 1 ? lat_a : lat_b) : -1;
         end
         if (st_push_o) begin
            stk.push_back(st_b_o); pushes++;
            if (first_push < 0) first_push = n;
            last_push = n;
         end
         if (done_o) begin
            done_n = n; got_err = 1'b1; got_res = result_o;
            check("error", 32'(error_o), 32'(exp_err));
            check("ready_low_at_done", 32'(cmd_ready_o), 32'd0);
            check("depth", 32'(depth_o), 32'(ref_stk.size()));
         end
      end
      st_pop_done_i = 1'b0;
      check("done_cycle", 32'(done_n), 32'(exp_n));
      if (got_err) check("result", 32'(got_res), 32'(exp_res));
      check("pops", 32'(pops), 32'(exp_pops));
      check("pushes", 32'(pushes), 32'(exp_pushes));
      check("first_push", 32'(first_push), 32'(exp_first));
      check("last_push", 32'(last_push), 32'(exp_pushes == 2 ? exp_n - 1 : exp_first));
      check("push_pop_excl", 32'(both), 32'd0);
      same = (stk.size() == ref_stk.size());
      for (int i = 0; i < stk.size() && i < ref_stk.size(); i++)
         if (stk[i] !== ref_stk[i]) same = 1'b0;
      check("stack_contents", 32'(same), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},  32'(cmd_ready_o), 32'd1);
      check({tag, "_push"},   32'(st_push_o),   32'd0);
      check({tag, "_pop"},    32'(st_pop_o),    32'd0);
      check({tag, "_st_b"},   32'(st_b_o),      32'd0);
      check({tag, "_result"}, 32'(result_o),    32'd0);
      check({tag, "_done"},   32'(done_o),      32'd0);
      check({tag, "_error"},  32'(error_o),     32'd0);
      check({tag, "_depth"},  32'(depth_o),     32'd0);
   endtask

   initial begin
      logic [7:0] v;
      int la, lb;
      // reset state
      repeat (3) @(negedge clk_i);
      check_reset_outputs("rst");
      reset_i = 1'b0;
      @(negedge clk_i);

      // directed: ADD, SUB wrap, DUP spacing, underflow, boundary latency, timeouts
      run(PUSHI, 8'h12, 1, 1);
      run(PUSHI, 8'h34, 1, 1);
      run(ADD,   8'h00, 1, 1);
      run(DROP,  8'h00, 3, 1);
      run(PUSHI, 8'h05, 1, 1);
      run(PUSHI, 8'h07, 1, 1);
      run(SUB,   8'h00, 2, 1);
      run(DROP,  8'h00, 1, 1);
      run(PUSHI, 8'hA5, 1, 1);
      run(DUP,   8'h00, 1, 1);
      run(DROP,  8'h00, 1, 1);
      run(ADD,   8'h00, 1, 1);
      run(DROP,  8'h00, 15, 1);
      run(PUSHI, 8'h01, 1, 1);
      run(PUSHI, 8'h02, 1, 1);
      run(ADD,   8'h00, 4, 0);
      run(PUSHI, 8'h09, 1, 1);
      run(DROP,  8'h00, 0, 1);

      // a stray pop response while idle must be ignored
      @(negedge clk_i);
      st_pop_done_i = 1'b1; st_out_i = 8'hFF;
      @(negedge clk_i);
      st_pop_done_i = 1'b0;
      check("stray_done", 32'(done_o), 32'd0);
      check("stray_depth", 32'(depth_o), 32'(ref_stk.size()));

      // random instruction mix against the model
      for (int k = 0; k < 150; k++) begin
         v  = 8'($urandom);
         la = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 15));
         lb = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 15));
         run(3'($urandom_range(0, 7)), v, la, lb);
      end

      // fill to capacity, then overflow on PUSHI and DUP
      while (ref_stk.size() < 256) run(PUSHI, 8'(ref_stk.size()), 1, 1);
      run(PUSHI, 8'h77, 1, 1);
      run(DUP,   8'h00, 1, 1);

      // reset while waiting for a pop response
      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_op_i = DROP;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      repeat (4) @(negedge clk_i);
      reset_i = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk_i);
      reset_i = 1'b0;
      stk.delete(); ref_stk.delete(); exp_res = 8'd0;

      run(DROP,  8'h00, 1, 1);
      run(PUSHI, 8'h3C, 1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
